// File: rtl/mult_datapath.sv
// Datapath for the sequential 8x8 shift-add multiplier: operand capture, nibble
// partial products, shift/accumulate, step counter and completion/abort reporting.
module mult_datapath #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     data_a,
  input  logic [W-1:0]     data_b,
  input  logic             sela,
  input  logic             selb,
  input  logic [1:0]       sel_shifter,
  input  logic             data_sel,
  input  logic             clk_en,
  input  logic             done_flag,
  output logic [CNT_W-1:0] count,
  output logic             changed,
  output logic [2*W-1:0]   product,
  output logic             product_valid,
  output logic             busy,
  output logic             error_flag
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned PW = 2 * W;

  typedef enum logic [1:0] {
    SH_0    = 2'b00,
    SH_4    = 2'b01,
    SH_8    = 2'b10,
    SH_ZERO = 2'b11
  } shift_e;

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             changed_q, changed_d;
  logic             pv_q, pv_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [H-1:0]     a_nib, b_nib;
  logic [W-1:0]     pp;
  logic [PW-1:0]    pp_ext;
  logic [PW-1:0]    shifted;
  shift_e           shift_sel;
  logic             start_cap;
  logic             finish_dec;
  logic             error_dec;

  assign a_nib  = sela ? a_q[W-1:H] : a_q[H-1:0];
  assign b_nib  = selb ? b_q[W-1:H] : b_q[H-1:0];
  assign pp     = W'(a_nib) * W'(b_nib);
  assign pp_ext = {{W{1'b0}}, pp};
  assign shift_sel = shift_e'(sel_shifter);

  always_comb begin
    shifted = '0;
    unique case (shift_sel)
      SH_0:    shifted = pp_ext;
      SH_4:    shifted = pp_ext << H;
      SH_8:    shifted = pp_ext << W;
      SH_ZERO: shifted = '0;
      default: shifted = '0;
    endcase
  end

  // start is only honoured when idle, so it can never coincide with the
  // busy-qualified finish/abort decodes below.
  assign start_cap  = start & ~busy_q;
  assign finish_dec = busy_q & done_flag &  data_sel & ~clk_en;
  assign error_dec  = busy_q & done_flag & ~data_sel & ~clk_en;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    count_d   = count_q;
    busy_d    = busy_q;
    err_d     = err_q;
    pv_d      = 1'b0;
    changed_d = busy_q & ((data_a != a_q) | (data_b != b_q));

    if (start_cap) begin
      a_d     = data_a;
      b_d     = data_b;
      count_d = CNT_W'(1);
      busy_d  = 1'b1;
      err_d   = 1'b0;
    end else if (done_flag) begin
      count_d = '0;
      busy_d  = 1'b0;
    end else if (busy_q && clk_en) begin
      count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end

    if (busy_q && clk_en) begin
      acc_d = data_sel ? shifted : acc_q + shifted;
    end

    if (finish_dec) begin
      product_d = acc_q;
      pv_d      = 1'b1;
    end

    if (error_dec) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      pv_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      pv_q      <= pv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign count         = count_q;
  assign changed       = changed_q;
  assign product       = product_q;
  assign product_valid = pv_q;
  assign busy          = busy_q;
  assign error_flag    = err_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath; a small FSM emulation drives the selects
// and results are checked against plain a*b arithmetic.
module tb_mult_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  data_a, data_b;
  logic        sela, selb;
  logic [1:0]  sel_shifter;
  logic        data_sel, clk_en, done_flag;
  logic [2:0]  count;
  logic        changed;
  logic [15:0] product;
  logic        product_valid, busy, error_flag;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_prod = '0;
  logic        exp_err  = 1'b0;

  typedef enum int {F_IDLE, F_S0, F_S1, F_S2, F_S3, F_FIN, F_ERR} fsm_e;

  mult_datapath #(.W(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .data_a(data_a), .data_b(data_b),
    .sela(sela), .selb(selb), .sel_shifter(sel_shifter), .data_sel(data_sel),
    .clk_en(clk_en), .done_flag(done_flag), .count(count), .changed(changed),
    .product(product), .product_valid(product_valid), .busy(busy),
    .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control word the multiplier FSM would present in each state.
  task automatic drive(input fsm_e st);
    sela = 1'b0; selb = 1'b0; sel_shifter = 2'b00;
    data_sel = 1'b0; clk_en = 1'b0; done_flag = 1'b0;
    case (st)
      F_IDLE: begin
        sela = 1'($urandom); selb = 1'($urandom);
        sel_shifter = 2'($urandom); data_sel = 1'($urandom);
      end
      F_S0: begin data_sel = 1'b1; clk_en = 1'b1; end
      F_S1: begin sela = 1'b1; sel_shifter = 2'b01; clk_en = 1'b1; end
      F_S2: begin selb = 1'b1; sel_shifter = 2'b01; clk_en = 1'b1; end
      F_S3: begin sela = 1'b1; selb = 1'b1; sel_shifter = 2'b10; clk_en = 1'b1; end
      F_FIN: begin done_flag = 1'b1; data_sel = 1'b1; end
      F_ERR: begin done_flag = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(F_IDLE);
      step();
      total++;
      if ({product, product_valid, busy, count, error_flag} !== {exp_prod, 1'b0, 1'b0, 3'd0, exp_err}) begin
        bad++;
        $display("FAIL idle: prod/pv/busy/cnt/err got %h/%b/%b/%0d/%b want %h/0/0/0/%b",
                 product, product_valid, busy, count, error_flag, exp_prod, exp_err);
      end
    end
  endtask

  // Full legal operation; optionally re-asserts start during S1..S3.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit spam);
    logic [15:0] want;
    want = 16'(a) * 16'(b);
    data_a = a; data_b = b; start = 1'b1;
    drive(F_IDLE);
    step();
    start = 1'b0;
    exp_err = 1'b0;
    total++;
    if ({count, busy, changed, error_flag, product_valid} !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL capture: cnt/busy/chg/err/pv got %0d/%b/%b/%b/%b want 1/1/0/0/0",
               count, busy, changed, error_flag, product_valid);
    end
    for (int k = 0; k < 4; k++) begin
      drive(fsm_e'(int'(F_S0) + k));
      start = spam && (k >= 1);
      step();
      total++;
      if ({count, busy, product_valid, changed} !== {3'(k + 2), 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL step%0d: cnt/busy/pv/chg got %0d/%b/%b/%b want %0d/1/0/0",
                 k, count, busy, product_valid, changed, k + 2);
      end
    end
    start = 1'b0;
    drive(F_FIN);
    step();
    exp_prod = want;
    total++;
    if ({product, product_valid, count, busy, error_flag} !== {want, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL finish %h*%h: prod/pv/cnt/busy/err got %h/%b/%0d/%b/%b want %h/1/0/0/0",
               a, b, product, product_valid, count, busy, error_flag, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; data_a = '0; data_b = '0;
    drive(F_IDLE);
    #3;
    total++;
    if ({count, changed, product, product_valid, busy, error_flag} !== 22'd0) begin
      bad++;
      $display("FAIL reset: cnt/chg/prod/pv/busy/err got %0d/%b/%h/%b/%b/%b want all 0",
               count, changed, product, product_valid, busy, error_flag);
    end
    step();
    step();
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    run_op(8'hA5, 8'h3C, 1'b0);
    idle(1);
    run_op(8'hFF, 8'hFF, 1'b0);
    idle(2);
    run_op(8'h00, 8'h7F, 1'b0);
    idle(1);
  endtask

  task automatic test_changed();
    int n;
    data_a = 8'h5A; data_b = 8'h3C; start = 1'b1;
    drive(F_IDLE);
    step();
    start = 1'b0;
    drive(F_S0); step();
    drive(F_S1); step();
    drive(F_S2); data_b = 8'h3D; step();
    total++;
    if ({changed, busy, count} !== {1'b1, 1'b1, 3'd4}) begin
      bad++;
      $display("FAIL changed_rise: chg/busy/cnt got %b/%b/%0d want 1/1/4", changed, busy, count);
    end
    drive(F_ERR);
    step();
    exp_err = 1'b1;
    total++;
    if ({error_flag, busy, count, product, product_valid} !== {1'b1, 1'b0, 3'd0, exp_prod, 1'b0}) begin
      bad++;
      $display("FAIL abort: err/busy/cnt/prod/pv got %b/%b/%0d/%h/%b want 1/0/0/%h/0",
               error_flag, busy, count, product, product_valid, exp_prod);
    end
    n = 0;
    while (changed === 1'b1 && n < 10) begin
      step();
      n++;
      total++;
      if ({product_valid, product, error_flag} !== {1'b0, exp_prod, 1'b1}) begin
        bad++;
        $display("FAIL error_hold: pv/prod/err got %b/%h/%b want 0/%h/1",
                 product_valid, product, error_flag, exp_prod);
      end
    end
    total++;
    if (n != 1 || changed !== 1'b0) begin
      bad++;
      $display("FAIL changed_fall: cycles %0d chg %b want 1 cycle, chg 0", n, changed);
    end
    data_b = 8'h3C;
    idle(2);
  endtask

  task automatic test_start_spam();
    run_op(8'hC3, 8'h9E, 1'b1);
    idle(1);
  endtask

  task automatic test_saturate();
    data_a = 8'h11; data_b = 8'h22; start = 1'b1;
    drive(F_IDLE);
    step();
    start = 1'b0;
    exp_err = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(F_S0);
      step();
      total++;
      if (count !== ((k + 2 > 7) ? 3'd7 : 3'(k + 2))) begin
        bad++;
        $display("FAIL saturate%0d: cnt got %0d want %0d", k, count, (k + 2 > 7) ? 7 : k + 2);
      end
    end
    drive(F_ERR);
    step();
    exp_err = 1'b1;
    total++;
    if ({error_flag, busy, count, product, product_valid} !== {1'b1, 1'b0, 3'd0, exp_prod, 1'b0}) begin
      bad++;
      $display("FAIL sat_abort: err/busy/cnt/prod/pv got %b/%b/%0d/%h/%b want 1/0/0/%h/0",
               error_flag, busy, count, product, product_valid, exp_prod);
    end
    drive(F_FIN);
    step();
    total++;
    if ({product_valid, product, error_flag} !== {1'b0, exp_prod, 1'b1}) begin
      bad++;
      $display("FAIL idle_done: pv/prod/err got %b/%h/%b want 0/%h/1",
               product_valid, product, error_flag, exp_prod);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    data_a = 8'hA5; data_b = 8'h3C; start = 1'b1;
    drive(F_IDLE);
    step();
    start = 1'b0;
    drive(F_S0); step();
    drive(F_S1); step();
    drive(F_S2);
    #2;
    rst = 1'b0;
    #1;
    exp_prod = '0;
    exp_err = 1'b0;
    total++;
    if ({count, changed, product, product_valid, busy, error_flag} !== 22'd0) begin
      bad++;
      $display("FAIL mid_reset: cnt/chg/prod/pv/busy/err got %0d/%b/%h/%b/%b/%b want all 0",
               count, changed, product, product_valid, busy, error_flag);
    end
    step();
    rst = 1'b1;
    idle(1);
    run_op(8'h12, 8'h34, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)) + 1);
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'h9C, 8'h47, 1'b0);
    run_op(8'h3B, 8'hE8, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_changed();
    test_start_spam();
    test_saturate();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
